simple_ntt_core: RTL and testbench

Four-point number-theoretic transform (NTT) engine over the prime field Z_q. It samples four coefficient words every clock and computes their 4-point forward NTT. It returns the transform bin selected by `index` on a single registered output word. It sits as a leaf arithmetic block under the polynomial-multiply datapath, fed directly from the coefficient buffer.

---
 rtl/simple_ntt_core.sv | 139 +++++++++++++
 tb/tb_simple_ntt_core.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_ntt_core.sv
// simple_ntt_core
//   Four-point number-theoretic transform over Z_q. Every cycle it samples four
//   coefficients and a bin index. Two rising edges later it presents bin
//   X[index] of their transform on output_buffer.
//
//   Pipeline:
//     stage A  reduces each coefficient mod q and registers it together with
//              index, so data and index always travel as a pair.
//     stage B  computes the radix-2 butterfly combinationally from the
//              stage-A registers and registers the selected bin.
//
//   Optional feature macro: SIMPLE_NTT_CORE_INVERSE_EN
//     When it is defined, the block computes the inverse NTT instead. The
//     twiddle becomes q-root and every bin is scaled by 4^-1 mod q in stage B.
//     Latency is the same in both builds.
//
//   Ports:
//     clk                          rising-edge clock
//     reset                        asynchronous, active-high; clears both stages
//     input_buffer0..input_buffer3 coefficients a0..a3 (unsigned, any value)
//     index                        selects the output bin k
//     output_buffer                registered X[k], always in [0, q-1]
module simple_ntt_core #(
  parameter int data_width      = 32,
  parameter int max_buffer_size = 4,
  parameter int modulus         = 3329,
  parameter int root            = 1729
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [data_width-1:0]              input_buffer0,
  input  logic [data_width-1:0]              input_buffer1,
  input  logic [data_width-1:0]              input_buffer2,
  input  logic [data_width-1:0]              input_buffer3,
  input  logic [$clog2(max_buffer_size)-1:0] index,
  output logic [data_width-1:0]              output_buffer
);

  localparam int iw = $clog2(max_buffer_size);

  localparam logic [data_width-1:0]   q_w    = data_width'(modulus);
  localparam logic [data_width:0]     q_ext  = (data_width + 1)'(modulus);
  localparam logic [2*data_width-1:0] q_wide = (2 * data_width)'(modulus);

`ifdef SIMPLE_NTT_CORE_INVERSE_EN
  localparam logic [data_width-1:0] twiddle = data_width'(modulus - root);
  // q = 1 (mod 4), so 3q+1 is divisible by 4 and 4*((3q+1)/4) = 1 (mod q).
  localparam logic [data_width-1:0] n_inv   = data_width'((3 * modulus + 1) / 4);
`else
  localparam logic [data_width-1:0] twiddle = data_width'(root);
`endif

  if (max_buffer_size != 4) begin : g_bad_size
    $error("simple_ntt_core: only max_buffer_size = 4 is supported");
  end
  if (longint'(modulus) >= (64'(1) << (data_width - 1))) begin : g_bad_modulus
    $error("simple_ntt_core: modulus must be below 2^(data_width-1)");
  end

  function automatic logic [data_width-1:0] mod_add(
    input logic [data_width-1:0] a,
    input logic [data_width-1:0] b
  );
    logic [data_width:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= q_ext) s = s - q_ext;
    return data_width'(s);
  endfunction

  // A borrow wraps modulo 2^(data_width+1). Adding q then lands on the
  // correct residue in the low bits.
  function automatic logic [data_width-1:0] mod_sub(
    input logic [data_width-1:0] a,
    input logic [data_width-1:0] b
  );
    logic [data_width:0] d;
    d = {1'b0, a} - {1'b0, b};
    if (a < b) d = d + q_ext;
    return data_width'(d);
  endfunction

  function automatic logic [data_width-1:0] mod_mul(
    input logic [data_width-1:0] a,
    input logic [data_width-1:0] b
  );
    logic [2*data_width-1:0] p;
    p = {{data_width{1'b0}}, a} * {{data_width{1'b0}}, b};
    p = p % q_wide;
    return data_width'(p);
  endfunction

  // Stage A: reduced coefficients and the index that accompanies them.
  logic [data_width-1:0] a_r [4];
  logic [iw-1:0]         index_r;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) a_r[i] <= '0;
      index_r <= '0;
    end else begin
      a_r[0]  <= input_buffer0 % q_w;
      a_r[1]  <= input_buffer1 % q_w;
      a_r[2]  <= input_buffer2 % q_w;
      a_r[3]  <= input_buffer3 % q_w;
      index_r <= index;
    end
  end

  // Stage B: butterfly followed by the bin select.
  logic [data_width-1:0] e0, e1, o0, o1;
  logic [data_width-1:0] bin    [4];
  logic [data_width-1:0] result [4];

  always_comb begin
    e0 = mod_add(a_r[0], a_r[2]);
    e1 = mod_sub(a_r[0], a_r[2]);
    o0 = mod_add(a_r[1], a_r[3]);
    o1 = mod_mul(mod_sub(a_r[1], a_r[3]), twiddle);

    bin[0] = mod_add(e0, o0);
    bin[1] = mod_add(e1, o1);
    bin[2] = mod_sub(e0, o0);
    bin[3] = mod_sub(e1, o1);

    for (int unsigned i = 0; i < 4; i++) begin
`ifdef SIMPLE_NTT_CORE_INVERSE_EN
      result[i] = mod_mul(bin[i], n_inv);
`else
      result[i] = bin[i];
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) output_buffer <= '0;
    else       output_buffer <= result[index_r];
  end

endmodule

// File: tb/tb_simple_ntt_core.sv
// Testbench for simple_ntt_core.
//   The reference model evaluates the 4-point transform directly as
//   sum_j a_j * w^(j*k) mod q. It uses 64-bit arithmetic and does not use the
//   butterfly. When SIMPLE_NTT_CORE_INVERSE_EN is defined, both the model and
//   the fixed-vector tests switch to the inverse transform.
module tb_simple_ntt_core;

  localparam longint unsigned Q    = 3329;
  localparam longint unsigned W    = 1729;
  localparam longint unsigned NINV = 2497;

  typedef struct packed {
    logic [3:0][31:0] a;
    logic [1:0]       k;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in0, in1, in2, in3;
  logic [1:0]  idx;
  logic [31:0] out_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  simple_ntt_core #(
    .data_width     (32),
    .max_buffer_size(4),
    .modulus        (3329),
    .root           (1729)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .input_buffer0(in0),
    .input_buffer1(in1),
    .input_buffer2(in2),
    .input_buffer3(in3),
    .index        (idx),
    .output_buffer(out_w)
  );

  function automatic longint unsigned pow_mod(input longint unsigned b, input int e);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % Q;
    return r;
  endfunction

  function automatic logic [31:0] golden(input vec_t v);
    longint unsigned tw, acc, aj;
`ifdef SIMPLE_NTT_CORE_INVERSE_EN
    tw = Q - W;
`else
    tw = W;
`endif
    acc = 0;
    for (int j = 0; j < 4; j++) begin
      aj  = 64'(v.a[j]) % Q;
      acc = (acc + aj * pow_mod(tw, j * int'(v.k))) % Q;
    end
`ifdef SIMPLE_NTT_CORE_INVERSE_EN
    acc = (acc * NINV) % Q;
`endif
    return 32'(acc);
  endfunction

  function automatic vec_t mk(input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3,
                              input logic [1:0] k);
    vec_t v;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3;
    v.k = k;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in0 = v.a[0]; in1 = v.a[1]; in2 = v.a[2]; in3 = v.a[3];
    idx = v.k;
  endtask

  task automatic test_reset();
    vec_t v;
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0));
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_w !== 32'd0) begin
      bad++;
      $display("FAIL reset_initial: got %0d expected 0", out_w);
    end

    // Fill the pipeline with live data, then hit reset between clock edges.
    @(negedge clk);
    reset = 1'b0;
    v = mk(1, 2, 3, 4, 0);
    drive(v);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_w !== golden(v)) begin
      bad++;
      $display("FAIL reset_prefill: got %0d expected %0d", out_w, golden(v));
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (out_w !== 32'd0) begin
      bad++;
      $display("FAIL reset_async: got %0d expected 0", out_w);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_w !== 32'd0) begin
      bad++;
      $display("FAIL reset_held: got %0d expected 0", out_w);
    end

    // After release, new data needs two edges to reach the output.
    @(negedge clk);
    reset = 1'b0;
    v = mk(1, 2, 3, 4, 1);
    drive(v);
    @(posedge clk);
    #1;
    total++;
    if (out_w !== 32'd0) begin
      bad++;
      $display("FAIL reset_flush_edge1: got %0d expected 0", out_w);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_w !== golden(v)) begin
      bad++;
      $display("FAIL reset_flush_edge2: got %0d expected %0d", out_w, golden(v));
    end
  endtask

`ifndef SIMPLE_NTT_CORE_INVERSE_EN
  task automatic test_forward_bins();
    logic [31:0] exp_bin [4];
    exp_bin = '{32'd10, 32'd3198, 32'd3327, 32'd127};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(mk(1, 2, 3, 4, 2'(k)));
      @(posedge clk);
      @(posedge clk);
      #1;
      total++;
      if (out_w !== exp_bin[k]) begin
        bad++;
        $display("FAIL forward_bin%0d: got %0d expected %0d", k, out_w, exp_bin[k]);
      end
    end
  endtask

  task automatic test_narrow_index();
    logic n1;
    n1 = 1'(3);
    @(negedge clk);
    drive(mk(1, 2, 3, 4, 0));
    idx = {1'b0, n1};
    @(posedge clk);
    @(posedge clk);
    #1;
    total++;
    if (out_w !== 32'd3198) begin
      bad++;
      $display("FAIL narrow_index: got %0d expected 3198", out_w);
    end
  endtask

  task automatic test_reduction();
    logic [31:0] exp_bin [4];
    exp_bin = '{32'd1, 32'd1729, 32'd3328, 32'd1600};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(mk(3329, 3330, 0, 0, 2'(k)));
      @(posedge clk);
      @(posedge clk);
      #1;
      total++;
      if (out_w !== exp_bin[k]) begin
        bad++;
        $display("FAIL reduction_bin%0d: got %0d expected %0d", k, out_w, exp_bin[k]);
      end
    end
  endtask
`else
  task automatic test_inverse();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(mk(10, 3198, 3327, 127, 2'(k)));
      @(posedge clk);
      @(posedge clk);
      #1;
      total++;
      if (out_w !== 32'(k + 1)) begin
        bad++;
        $display("FAIL inverse_bin%0d: got %0d expected %0d", k, out_w, k + 1);
      end
    end
  endtask
`endif

  // Drives a new set every negedge. The set popped from the queue is the one
  // driven two negedges earlier, which is the set whose result is now on the
  // output.
  task automatic test_back_to_back();
    vec_t pend [$];
    vec_t v, old;
    for (int n = 0; n < 42; n++) begin
      @(negedge clk);
      if (pend.size() == 2) begin
        old = pend.pop_front();
        total++;
        if (out_w !== golden(old)) begin
          bad++;
          $display("FAIL back_to_back[%0d]: got %0d expected %0d", n, out_w, golden(old));
        end
      end
      if (n < 40) begin
        for (int j = 0; j < 4; j++) begin
          if ($urandom_range(3) == 0) v.a[j] = 32'($urandom_range(3331, 3327));
          else                        v.a[j] = $urandom;
        end
        v.k = 2'($urandom_range(3));
        drive(v);
        pend.push_back(v);
      end
    end
  endtask

  initial begin
    test_reset();
`ifndef SIMPLE_NTT_CORE_INVERSE_EN
    test_forward_bins();
    test_narrow_index();
    test_reduction();
`else
    test_inverse();
`endif
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
